// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter from NUM_PORTS requesters onto one external memory bus.
// Ports: clk, rst (async active-low), port_* requester side, mem_addr/data_in/strobes/data_out/mem_ready bus side; optional MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
  parameter int WORD_SIZE      = 32,
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           port_req,
  input  logic [NUM_PORTS-1:0]           port_wr,
  input  logic [NUM_PORTS*32-1:0]        port_addr,
  input  logic [NUM_PORTS*WORD_SIZE-1:0] port_wdata,
  output logic [WORD_SIZE-1:0]           port_rdata,
  output logic [NUM_PORTS-1:0]           port_ack,
  output logic [NUM_PORTS-1:0]           port_stall,
  output logic [NUM_PORTS-1:0]           port_err,
  output logic [31:0]                    mem_addr,
  output logic [WORD_SIZE-1:0]           data_in,
  output logic                           en_ext_mem_re,
  output logic                           en_ext_mem_wr,
  input  logic [WORD_SIZE-1:0]           data_out,
  input  logic                           mem_ready
);

  localparam int GW = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("mem_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t                 state;
  logic [GW-1:0]          grant;
  logic [GW-1:0]          last_grant;
  logic [GW-1:0]          pick;
  logic [NUM_PORTS-1:0]   grant_oh;
  logic [2*NUM_PORTS-1:0] dbl;
  logic [NUM_PORTS-1:0]   rot;
  logic                   sel_wr;
  logic [31:0]            sel_addr;
  logic [WORD_SIZE-1:0]   sel_wdata;
  int                     off;
  int                     tmp;

  // Rotate requests so bit 0 is the port after last_grant,
  // then the lowest set bit is the round-robin winner.
  always_comb begin
    dbl = {port_req, port_req};
    rot = NUM_PORTS'(dbl >> (int'(last_grant) + 1));
    off = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (rot[i]) off = i;
    tmp = int'(last_grant) + 1 + off;
    if (tmp >= NUM_PORTS) tmp = tmp - NUM_PORTS;
    pick = GW'(tmp);
  end

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    grant_oh  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick == GW'(i)) begin
        sel_wr    = port_wr[i];
        sel_addr  = port_addr[i*32 +: 32];
        sel_wdata = port_wdata[i*WORD_SIZE +: WORD_SIZE];
      end
      grant_oh[i] = (grant == GW'(i));
    end
  end

  assign port_stall = port_req & ~port_ack;

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic [15:0] tcnt;
  logic        tout;
  assign tout = (tcnt + 16'd1) == 16'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= GW'(NUM_PORTS - 1);
      port_rdata    <= '0;
      port_ack      <= '0;
      port_err      <= '0;
      mem_addr      <= '0;
      data_in       <= '0;
      en_ext_mem_re <= 1'b0;
      en_ext_mem_wr <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      tcnt          <= '0;
`endif
    end else begin
      port_ack <= '0;
      port_err <= '0;
      unique case (state)
        IDLE: begin
          if (|port_req) begin
            grant         <= pick;
            mem_addr      <= sel_addr;
            data_in       <= sel_wdata;
            en_ext_mem_re <= ~sel_wr;
            en_ext_mem_wr <= sel_wr;
`ifdef MEM_ARBITER_TIMEOUT_EN
            tcnt          <= '0;
`endif
            state         <= BUSY;
          end
        end
        BUSY: begin
          // A ready on the timeout edge still counts as success.
          if (mem_ready) begin
            if (en_ext_mem_re) port_rdata <= data_out;
            port_ack      <= grant_oh;
            last_grant    <= grant;
            en_ext_mem_re <= 1'b0;
            en_ext_mem_wr <= 1'b0;
            state         <= ACK;
          end
`ifdef MEM_ARBITER_TIMEOUT_EN
          else if (tout) begin
            port_rdata    <= '0;
            port_ack      <= grant_oh;
            port_err      <= grant_oh;
            last_grant    <= grant;
            en_ext_mem_re <= 1'b0;
            en_ext_mem_wr <= 1'b0;
            state         <= ACK;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
`endif
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory responder.
// Ports: none; drives the DUT, checks acks, read data, bus fields and reset behaviour.
module tb_mem_arbiter;

  localparam int W = 32;
  localparam int N = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   port_req;
  logic [N-1:0]   port_wr;
  logic [N*32-1:0] port_addr;
  logic [N*W-1:0] port_wdata;
  logic [W-1:0]   port_rdata;
  logic [N-1:0]   port_ack;
  logic [N-1:0]   port_stall;
  logic [N-1:0]   port_err;
  logic [31:0]    mem_addr;
  logic [W-1:0]   data_in;
  logic           en_ext_mem_re;
  logic           en_ext_mem_wr;
  logic [W-1:0]   data_out;
  logic           mem_ready;

  mem_arbiter #(
    .WORD_SIZE(W), .NUM_PORTS(N), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .port_req(port_req), .port_wr(port_wr),
    .port_addr(port_addr), .port_wdata(port_wdata),
    .port_rdata(port_rdata), .port_ack(port_ack),
    .port_stall(port_stall), .port_err(port_err),
    .mem_addr(mem_addr), .data_in(data_in),
    .en_ext_mem_re(en_ext_mem_re), .en_ext_mem_wr(en_ext_mem_wr),
    .data_out(data_out), .mem_ready(mem_ready)
  );

  typedef struct {
    int         port;
    logic [W-1:0] rdata;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         fails  = 0;
  int         acks   = 0;
  int         delay  = 3;
  int         bcnt   = 0;
  logic       idle_pulse = 1'b0;
  logic [W-1:0] model_rdata = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rd_val(logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return a ^ 32'hCAFE_0000;
  endfunction

  task automatic set_port(int p, logic wr, logic [31:0] a, logic [W-1:0] d);
    port_wr[p]              = wr;
    port_addr[p*32 +: 32]   = a;
    port_wdata[p*W +: W]    = d;
  endtask

  task automatic push(int p, logic rd, logic [31:0] a, logic err);
    exp_t e;
    if (err) model_rdata = '0;
    else if (rd) model_rdata = rd_val(a);
    e.port  = p;
    e.rdata = model_rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic wait_acks(int target);
    int k = 0;
    while (acks < target && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    check("ack_wait", 64'(acks >= target), 64'd1);
  endtask

  // Memory model: ready after `delay` BUSY cycles, data from rd_val.
  initial begin
    mem_ready = 1'b0;
    data_out  = '0;
    forever begin
      @(negedge clk);
      if (en_ext_mem_re | en_ext_mem_wr) bcnt++;
      else bcnt = 0;
      data_out  = rd_val(mem_addr);
      mem_ready = ((en_ext_mem_re | en_ext_mem_wr) && bcnt == delay)
                  || idle_pulse;
    end
  end

  // Ack monitor: every pulse pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (port_ack != '0) begin
        acks++;
        check("stall", 64'(port_stall), 64'(port_req & ~port_ack));
        if (sb.size() == 0) begin
          check("unexp_ack", 64'(port_ack), 64'd0);
        end else begin
          e = sb.pop_front();
          check("ack_port", 64'(port_ack), 64'd1 << e.port);
          check("rdata", 64'(port_rdata), 64'(e.rdata));
          check("err", 64'(port_err), 64'(e.err) << e.port);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int k;
    int tgt;
    rst        = 1'b0;
    port_req   = '0;
    port_wr    = '0;
    port_addr  = '0;
    port_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rdata", 64'(port_rdata), 64'd0);
    check("rst_ack", 64'(port_ack), 64'd0);
    check("rst_err", 64'(port_err), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_din", 64'(data_in), 64'd0);
    check("rst_strb", 64'({en_ext_mem_re, en_ext_mem_wr}), 64'd0);
    rst = 1'b1;
    @(negedge clk); #1;

    // mem_ready while idle must be ignored
    a0 = acks;
    idle_pulse = 1'b1;
    @(negedge clk); #1;
    idle_pulse = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("idle_ack", 64'(acks), 64'(a0));
    check("idle_strb", 64'({en_ext_mem_re, en_ext_mem_wr}), 64'd0);

    // port0 read, ready after 3 busy cycles
    delay = 3;
    set_port(0, 1'b0, 32'h100, '0);
    push(0, 1'b1, 32'h100, 1'b0);
    port_req = 2'b01;
    wait_acks(1);
    port_req = '0;

    // port1 write
    delay = 2;
    set_port(1, 1'b1, 32'h200, 32'h1234_5678);
    push(1, 1'b0, 32'h200, 1'b0);
    port_req = 2'b10;
    k = 0;
    while (!en_ext_mem_wr && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    check("wr_strb", 64'({en_ext_mem_wr, en_ext_mem_re}), 64'd2);
    check("wr_addr", 64'(mem_addr), 64'h200);
    check("wr_din", 64'(data_in), 64'h1234_5678);
    wait_acks(2);
    port_req = '0;
    check("wr_strb_off", 64'(en_ext_mem_wr), 64'd0);

    // both ports from reset: 0, 1, 0
    rst = 1'b0;
    @(negedge clk); #1;
    model_rdata = '0;
    rst = 1'b1;
    delay = 3;
    set_port(0, 1'b0, 32'h300, '0);
    set_port(1, 1'b0, 32'h400, '0);
    push(0, 1'b1, 32'h300, 1'b0);
    push(1, 1'b1, 32'h400, 1'b0);
    push(0, 1'b1, 32'h300, 1'b0);
    port_req = 2'b11;
    wait_acks(5);
    port_req = '0;

    // memory never ready
    delay = 1000;
    set_port(1, 1'b0, 32'h500, '0);
`ifdef MEM_ARBITER_TIMEOUT_EN
    push(1, 1'b1, 32'h500, 1'b1);
    port_req = 2'b10;
    wait_acks(6);
    port_req = '0;
    tgt = 7;
`else
    port_req = 2'b10;
    repeat (100) @(negedge clk);
    #1;
    check("hang_ack", 64'(acks), 64'd5);
    check("hang_busy", 64'(en_ext_mem_re), 64'd1);
    rst = 1'b0;
    #1;
    check("rst_busy_strb",
          64'({en_ext_mem_re, en_ext_mem_wr}), 64'd0);
    port_req = '0;
    @(negedge clk); #1;
    check("rst_busy_ack", 64'(acks), 64'd5);
    model_rdata = '0;
    rst = 1'b1;
    tgt = 6;
`endif

    // after reset port0 wins first
    delay = 2;
    set_port(0, 1'b0, 32'h600, '0);
    set_port(1, 1'b0, 32'h700, '0);
    push(0, 1'b1, 32'h600, 1'b0);
    port_req = 2'b11;
    wait_acks(tgt);
    port_req = '0;
    repeat (5) @(negedge clk);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("ack_total", 64'(acks), 64'(tgt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
